// File: rtl/plataform_scroller.sv
// Vertical scroller for N_PLAT platforms that move together on one tick divider.
// Each platform wraps around the visible screen height and pulses its wrap bit.
// plat_start is registered; plat_end is derived combinationally from it.
module plataform_scroller #(
    parameter int unsigned N_PLAT   = 3,
    parameter int unsigned HEIGHT   = 30,
    parameter int unsigned SPACING  = 160,
    parameter int unsigned SCREEN_H = 480,
    parameter int unsigned TICK_DIV = 840000,
    parameter int unsigned CNT_W    = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [1:0]             speed,
    input  logic                   dir,
    output logic [N_PLAT*10-1:0]   plat_start,
    output logic [N_PLAT*10-1:0]   plat_end,
    output logic                   tick,
    output logic [N_PLAT-1:0]      wrapped
);

    localparam logic [10:0]      ScreenH  = 11'(SCREEN_H);
    localparam logic [9:0]       Height   = 10'(HEIGHT);
    localparam logic [CNT_W-1:0] TickTerm = CNT_W'(TICK_DIV);

    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [N_PLAT-1:0][9:0]    start_q, start_d;
    logic                      tick_q, tick_d;
    logic [N_PLAT-1:0]         wrapped_q, wrapped_d;
    logic                      update;
    // 11-bit intermediates so start+s cannot overflow before the compare
    logic [N_PLAT-1:0][10:0]   down_sum;
    logic [N_PLAT-1:0][10:0]   up_sum;
    logic [N_PLAT-1:0][9:0]    end_w;

    assign update = enable && (cnt_q == TickTerm);

    // Tick divider: counts enabled edges and rolls over at the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (enable) begin
            if (cnt_q == TickTerm) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Next positions and wrap flags; speed and dir only matter on the update edge.
    always_comb begin
        start_d   = start_q;
        tick_d    = 1'b0;
        wrapped_d = '0;
        for (int i = 0; i < N_PLAT; i++) begin
            down_sum[i] = 11'(start_q[i]) + 11'(speed);
            up_sum[i]   = 11'(start_q[i]) + ScreenH - 11'(speed);
        end
        if (update) begin
            tick_d = 1'b1;
            for (int i = 0; i < N_PLAT; i++) begin
                if (!dir) begin
                    if (down_sum[i] >= ScreenH) begin
                        start_d[i]   = 10'(down_sum[i] - ScreenH);
                        wrapped_d[i] = 1'b1;
                    end else begin
                        start_d[i]   = down_sum[i][9:0];
                    end
                end else begin
                    if (start_q[i] < 10'(speed)) begin
                        start_d[i]   = up_sum[i][9:0];
                        wrapped_d[i] = 1'b1;
                    end else begin
                        start_d[i]   = start_q[i] - 10'(speed);
                    end
                end
            end
        end
    end

    // State registers with synchronous reset to the staggered start rows.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            wrapped_q <= '0;
            for (int i = 0; i < N_PLAT; i++) begin
                start_q[i] <= 10'(i * SPACING);
            end
        end else begin
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            wrapped_q <= wrapped_d;
            start_q   <= start_d;
        end
    end

    // Bottom rows: plain 10-bit add, no wrap.
    always_comb begin
        for (int i = 0; i < N_PLAT; i++) begin
            end_w[i] = start_q[i] + Height;
        end
    end

    assign plat_start = start_q;
    assign plat_end   = end_w;
    assign tick       = tick_q;
    assign wrapped    = wrapped_q;

endmodule
